// File: rtl/ddr3_phy_pkg.sv
// -----------------------------------------------------------------------------
// ddr3_phy_pkg
// Shared types and widths for the DDR3 byte-lane read-leveling logic.
//   - Field widths of the DQS I/O block interface (delay, latency offset,
//     base read latency) and the depth of the READ pulse shift register.
//   - Read-leveling FSM state encoding (rdlvl_state_t).
//   - win_center(): midpoint of the passing delay window.
// -----------------------------------------------------------------------------
package ddr3_phy_pkg;

    localparam int DLY_W       = 7;
    localparam int LATOFS_W    = 3;
    localparam int RDLAT_W     = 4;
    localparam int PULSE_DEPTH = 24;
    // rd_lat + lat_ofs fits in 5 bits (15 + 7 = 22)
    localparam int LAT_W       = 5;

    // Fixed state codes, kept stable so captured state values stay readable
    // in older debug tooling.
    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_SETTLE       = 4'd1;
    localparam logic [3:0] S_ISSUE        = 4'd2;
    localparam logic [3:0] S_WAIT_DV      = 4'd3;
    localparam logic [3:0] S_EVAL         = 4'd4;
    localparam logic [3:0] S_CENTER       = 4'd5;
    localparam logic [3:0] S_SETTLE_FINAL = 4'd6;
    localparam logic [3:0] S_DONE         = 4'd7;
    localparam logic [3:0] S_ERR          = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE         = S_IDLE,
        ST_SETTLE       = S_SETTLE,
        ST_ISSUE        = S_ISSUE,
        ST_WAIT_DV      = S_WAIT_DV,
        ST_EVAL         = S_EVAL,
        ST_CENTER       = S_CENTER,
        ST_SETTLE_FINAL = S_SETTLE_FINAL,
        ST_DONE         = S_DONE,
        ST_ERR          = S_ERR
    } rdlvl_state_t;

    // Midpoint of [a, b]; the sum is carried one bit wider so it cannot wrap.
    function automatic logic [DLY_W-1:0] win_center(input logic [DLY_W-1:0] a,
                                                    input logic [DLY_W-1:0] b);
        logic [DLY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DLY_W:1];
    endfunction

endpackage

// File: rtl/ddr3_rdpulse_gen.sv
// -----------------------------------------------------------------------------
// ddr3_rdpulse_gen
// Generates the DQS I/O block READ strobe. A trigger in cycle t makes o_read
// high for cycles t+L .. t+L+BURST_CYC-1, with L = i_rd_lat + i_lat_ofs
// sampled at trigger time. Overlapping bursts OR together.
// Ports:
//   i_sclk     system clock
//   i_rst      synchronous active-high reset (clears all pending pulses)
//   i_trig     read trigger (functional or calibration read)
//   i_rd_lat   base read latency, sclk cycles
//   i_lat_ofs  calibrated latency offset
//   o_read     READ strobe to the DQS I/O block (registered)
// -----------------------------------------------------------------------------
module ddr3_rdpulse_gen
    import ddr3_phy_pkg::*;
#(
    parameter int BURST_CYC = 2
)(
    input  logic                i_sclk,
    input  logic                i_rst,
    input  logic                i_trig,
    input  logic [RDLAT_W-1:0]  i_rd_lat,
    input  logic [LATOFS_W-1:0] i_lat_ofs,
    output logic                o_read
);

    localparam logic [PULSE_DEPTH-1:0] BURST_MASK =
        PULSE_DEPTH'((64'd1 << BURST_CYC) - 64'd1);

    // Bit k of r_sr = "read is high k cycles from now"; bit 0 drives o_read.
    logic [PULSE_DEPTH-1:0] r_sr;
    logic [PULSE_DEPTH-1:0] w_sr_next;
    logic [PULSE_DEPTH-1:0] w_ins;
    logic [LAT_W-1:0]       w_lat;
    logic [LAT_W-1:0]       w_shift;

    assign w_lat = LAT_W'(i_rd_lat) + LAT_W'(i_lat_ofs);

    // The burst lands at bit L-1 so that after L-1 more shifts it reaches
    // bit 0 in cycle t+L. A total latency of 0 cannot be met by a registered
    // strobe, so it is treated as 1.
    assign w_shift = (w_lat == '0) ? '0 : (w_lat - LAT_W'(1));
    assign w_ins   = i_trig ? (BURST_MASK << w_shift) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < PULSE_DEPTH; gi = gi + 1) begin : g_sr
            if (gi == PULSE_DEPTH - 1) begin : g_top
                assign w_sr_next[gi] = w_ins[gi];
            end else begin : g_mid
                assign w_sr_next[gi] = r_sr[gi+1] | w_ins[gi];
            end
        end
    endgenerate

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

    assign o_read = r_sr[0];

endmodule

// File: rtl/ddr3_rdlvl_ctrl.sv
// -----------------------------------------------------------------------------
// ddr3_rdlvl_ctrl
// Read-leveling controller for one DDR3 byte lane. On i_cal_start it sweeps
// the DQS dynamic delay (0..DLY_MAX) for each read-latency offset (0..7),
// running TRIALS trial reads per setting, finds the first passing window of
// at least MIN_WIN taps and parks the delay at its centre. It also owns the
// READ pulse generator for both trial and functional reads.
// Ports:
//   i_sclk, i_rst            clock, synchronous active-high reset
//   i_cal_start              one-cycle calibration start pulse
//   o_cal_rd_req/i_cal_rd_ack  trial-read handshake with the sequencer
//   i_rd_cmd                 functional read (ignored while o_cal_busy)
//   i_rd_lat                 base read latency
//   i_datavalid              DATAVALID from the DQS I/O block
//   o_read, o_dyndelay, o_dyndelpol  to the DQS I/O block
//   o_lat_ofs                read-latency offset added to i_rd_lat
//   o_cal_busy/done/err      calibration status (done/err sticky)
//   o_win_first/o_win_last   bounds of the passing delay window
// -----------------------------------------------------------------------------
module ddr3_rdlvl_ctrl
    import ddr3_phy_pkg::*;
#(
    parameter int BURST_CYC  = 2,
    parameter int TRIALS     = 4,
    parameter int SETTLE     = 8,
    parameter int DV_TIMEOUT = 16,
    parameter int DLY_MAX    = 127,
    parameter int MIN_WIN    = 4
)(
    input  logic                i_sclk,
    input  logic                i_rst,
    input  logic                i_cal_start,
    output logic                o_cal_rd_req,
    input  logic                i_cal_rd_ack,
    input  logic                i_rd_cmd,
    input  logic [RDLAT_W-1:0]  i_rd_lat,
    input  logic                i_datavalid,
    output logic                o_read,
    output logic [DLY_W-1:0]    o_dyndelay,
    output logic                o_dyndelpol,
    output logic [LATOFS_W-1:0] o_lat_ofs,
    output logic                o_cal_busy,
    output logic                o_cal_done,
    output logic                o_cal_err,
    output logic [DLY_W-1:0]    o_win_first,
    output logic [DLY_W-1:0]    o_win_last
);

    // Shared settle / datavalid-timeout counter and trial counter.
    localparam int CNT_W = 8;
    localparam logic [DLY_W-1:0]    DLY_MAX_V  = DLY_W'(DLY_MAX);
    localparam logic [LATOFS_W-1:0] LATOFS_MAX = '1;

    rdlvl_state_t          r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_trial;
    logic                  r_pass;
    logic                  r_win_open;
    logic [DLY_W-1:0]      r_dyndelay;
    logic [LATOFS_W-1:0]   r_lat_ofs;
    logic                  r_dyndelpol;
    logic                  r_cal_busy;
    logic                  r_cal_done;
    logic                  r_cal_err;
    logic [DLY_W-1:0]      r_win_first;
    logic [DLY_W-1:0]      r_win_last;

    logic                  w_trig;
    logic [DLY_W:0]        w_width;

    assign w_trig  = (i_rd_cmd & ~r_cal_busy) | i_cal_rd_ack;
    assign w_width = {1'b0, r_win_last} - {1'b0, r_win_first} + (DLY_W+1)'(1);

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_trial     <= '0;
            r_pass      <= 1'b0;
            r_win_open  <= 1'b0;
            r_dyndelay  <= '0;
            r_lat_ofs   <= '0;
            r_dyndelpol <= 1'b0;
            r_cal_busy  <= 1'b0;
            r_cal_done  <= 1'b0;
            r_cal_err   <= 1'b0;
            r_win_first <= '0;
            r_win_last  <= '0;
        end else begin
            // Positive delay only; kept as a register so the pin is flop-driven.
            r_dyndelpol <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Only IDLE listens to cal_start, so a pulse while busy is ignored.
                    if (i_cal_start) begin
                        r_dyndelay  <= '0;
                        r_lat_ofs   <= '0;
                        r_cal_done  <= 1'b0;
                        r_cal_err   <= 1'b0;
                        r_win_first <= '0;
                        r_win_last  <= '0;
                        r_win_open  <= 1'b0;
                        r_cal_busy  <= 1'b1;
                        r_cnt       <= '0;
                        r_trial     <= '0;
                        r_state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (i_cal_rd_ack) begin
                        // Timer reads 1 in the first WAIT_DV cycle.
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_WAIT_DV;
                    end
                end
                ST_WAIT_DV: begin
                    // datavalid is checked before expiry, so it still passes
                    // in the cycle the timer reads DV_TIMEOUT.
                    if (i_datavalid) begin
                        if (r_trial == CNT_W'(TRIALS - 1)) begin
                            r_pass  <= 1'b1;
                            r_state <= ST_EVAL;
                        end else begin
                            r_trial <= r_trial + CNT_W'(1);
                            r_state <= ST_ISSUE;
                        end
                    end else if (r_cnt == CNT_W'(DV_TIMEOUT)) begin
                        r_pass  <= 1'b0;
                        r_state <= ST_EVAL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    r_trial <= '0;
                    r_cnt   <= '0;
                    if (r_pass) begin
                        if (!r_win_open) begin
                            r_win_first <= r_dyndelay;
                        end
                        r_win_last <= r_dyndelay;
                        r_win_open <= 1'b1;
                    end
                    if (!r_pass && r_win_open) begin
                        // First failure after a pass ends the window.
                        r_win_open <= 1'b0;
                        r_state    <= ST_CENTER;
                    end else if (r_dyndelay < DLY_MAX_V) begin
                        r_dyndelay <= r_dyndelay + DLY_W'(1);
                        r_state    <= ST_SETTLE;
                    end else if (r_pass || r_win_open) begin
                        // Window runs to the end of the delay range.
                        r_state <= ST_CENTER;
                    end else if (r_lat_ofs != LATOFS_MAX) begin
                        r_lat_ofs  <= r_lat_ofs + LATOFS_W'(1);
                        r_dyndelay <= '0;
                        r_state    <= ST_SETTLE;
                    end else begin
                        r_state <= ST_ERR;
                    end
                end
                ST_CENTER: begin
                    r_trial <= '0;
                    r_cnt   <= '0;
                    if (w_width < (DLY_W+1)'(MIN_WIN)) begin
                        // Too narrow to trust: discard and try the next offset.
                        r_win_first <= '0;
                        r_win_last  <= '0;
                        r_win_open  <= 1'b0;
                        if (r_lat_ofs != LATOFS_MAX) begin
                            r_lat_ofs  <= r_lat_ofs + LATOFS_W'(1);
                            r_dyndelay <= '0;
                            r_state    <= ST_SETTLE;
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end else begin
                        r_dyndelay <= win_center(r_win_first, r_win_last);
                        r_state    <= ST_SETTLE_FINAL;
                    end
                end
                ST_SETTLE_FINAL: begin
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_cal_done <= 1'b1;
                    r_cal_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                ST_ERR: begin
                    r_cal_err  <= 1'b1;
                    r_cal_busy <= 1'b0;
                    r_dyndelay <= '0;
                    r_lat_ofs  <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ddr3_rdpulse_gen #(
        .BURST_CYC (BURST_CYC)
    ) u_rdpulse (
        .i_sclk    (i_sclk),
        .i_rst     (i_rst),
        .i_trig    (w_trig),
        .i_rd_lat  (i_rd_lat),
        .i_lat_ofs (r_lat_ofs),
        .o_read    (o_read)
    );

    assign o_cal_rd_req = (r_state == ST_ISSUE);
    assign o_dyndelay   = r_dyndelay;
    assign o_dyndelpol  = r_dyndelpol;
    assign o_lat_ofs    = r_lat_ofs;
    assign o_cal_busy   = r_cal_busy;
    assign o_cal_done   = r_cal_done;
    assign o_cal_err    = r_cal_err;
    assign o_win_first  = r_win_first;
    assign o_win_last   = r_win_last;

endmodule

// File: tb/tb_ddr3_rdlvl_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ddr3_rdlvl_ctrl
// Self-checking bench for ddr3_rdlvl_ctrl. A sequencer/DQS model acks trial
// reads and returns datavalid when the current (lat_ofs, dyndelay) lies in
// a per-offset passing range; the expected calibration outcome and the
// number of trial reads per setting are derived from those ranges.
// -----------------------------------------------------------------------------
module tb_ddr3_rdlvl_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cal_start;
    logic       ack;
    logic       rd_cmd;
    logic [3:0] rd_lat;
    logic       dv;

    logic       o_cal_rd_req;
    logic       o_read;
    logic [6:0] o_dyndelay;
    logic       o_dyndelpol;
    logic [2:0] o_lat_ofs;
    logic       o_cal_busy;
    logic       o_cal_done;
    logic       o_cal_err;
    logic [6:0] o_win_first;
    logic [6:0] o_win_last;

    always #5 clk = ~clk;

    ddr3_rdlvl_ctrl dut (
        .i_sclk       (clk),
        .i_rst        (rst),
        .i_cal_start  (cal_start),
        .o_cal_rd_req (o_cal_rd_req),
        .i_cal_rd_ack (ack),
        .i_rd_cmd     (rd_cmd),
        .i_rd_lat     (rd_lat),
        .i_datavalid  (dv),
        .o_read       (o_read),
        .o_dyndelay   (o_dyndelay),
        .o_dyndelpol  (o_dyndelpol),
        .o_lat_ofs    (o_lat_ofs),
        .o_cal_busy   (o_cal_busy),
        .o_cal_done   (o_cal_done),
        .o_cal_err    (o_cal_err),
        .o_win_first  (o_win_first),
        .o_win_last   (o_win_last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- lane model ----------------
    int win_lo [8];
    int win_hi [8];
    bit model_en    = 1'b0;
    bit rand_timing = 1'b0;
    bit noise_en    = 1'b0;
    int fixed_d     = 3;
    int ack_cnt  [8][128];
    int exp_acks [8][128];
    int cyc      = 0;
    int ack_wait = 0;
    bit dv_pend  = 1'b0;
    int dv_at    = 0;
    int last_ack_cyc = -1;
    int last_ack_dly = -1;

    function automatic bit pass_at(int l, int d);
        return (d >= win_lo[l]) && (d <= win_hi[l]);
    endfunction

    // A trial passes only if datavalid lands within 16 cycles of the ack.
    function automatic bit eff_pass(int l, int d);
        return pass_at(l, d) && (rand_timing || fixed_d <= 16);
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        ack = 1'b0;
        dv  = 1'b0;
        if (rst) begin
            dv_pend  = 1'b0;
            ack_wait = 0;
        end else if (model_en) begin
            if (dv_pend && cyc == dv_at) begin
                dv      = 1'b1;
                dv_pend = 1'b0;
            end
            if (o_cal_rd_req) begin
                if (ack_wait == 0) begin
                    ack = 1'b1;
                    ack_cnt[o_lat_ofs][o_dyndelay] = ack_cnt[o_lat_ofs][o_dyndelay] + 1;
                    last_ack_cyc = cyc;
                    last_ack_dly = int'(o_dyndelay);
                    if (pass_at(int'(o_lat_ofs), int'(o_dyndelay))) begin
                        dv_pend = 1'b1;
                        dv_at   = cyc + (rand_timing ? int'($urandom_range(1, 16)) : fixed_d);
                    end else if (noise_en) begin
                        dv = 1'b1;   // lands while the controller is still in ISSUE
                    end
                    ack_wait = rand_timing ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    ack_wait = ack_wait - 1;
                end
            end
        end
    end

    task automatic set_no_windows();
        for (int l = 0; l < 8; l++) begin
            win_lo[l] = 200;
            win_hi[l] = -1;
        end
    endtask

    // Expected result: at each offset, sweep delays from 0; the first passing
    // run is the window; it ends at the first failure (or at 127). Accept it
    // if at least 4 wide, otherwise move to the next offset.
    task automatic compute_expect(output bit ok, output int e_lat, output int e_dly,
                                  output int e_f, output int e_l);
        ok = 1'b0; e_lat = 0; e_dly = 0; e_f = 0; e_l = 0;
        foreach (exp_acks[a, b]) exp_acks[a][b] = 0;
        for (int l = 0; l < 8; l++) begin
            int first_p;
            int last_p;
            int stop;
            first_p = -1;
            last_p  = -1;
            stop    = 127;
            for (int d = 0; d < 128; d++) begin
                if (eff_pass(l, d)) begin
                    if (first_p < 0) first_p = d;
                    last_p = d;
                end else if (first_p >= 0) begin
                    stop = d;
                    break;
                end
            end
            for (int d = 0; d <= stop; d++) exp_acks[l][d] = eff_pass(l, d) ? 4 : 1;
            if (first_p >= 0 && (last_p - first_p + 1) >= 4) begin
                ok    = 1'b1;
                e_lat = l;
                e_f   = first_p;
                e_l   = last_p;
                e_dly = (first_p + last_p) / 2;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [29:0] outs;
        rst = 1'b1; cal_start = 1'b0; rd_cmd = 1'b0; rd_lat = 4'd0;
        repeat (3) @(negedge clk);
        outs = {o_cal_rd_req, o_read, o_dyndelay, o_dyndelpol, o_lat_ofs, o_cal_busy,
                o_cal_done, o_cal_err, o_win_first, o_win_last};
        n_tests++;
        if (outs !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_pulse();
        bit exp_rd [0:319];
        foreach (exp_rd[i]) exp_rd[i] = 1'b0;
        model_en = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            n_tests++;
            if (o_read !== exp_rd[k]) begin
                n_fail++;
                $display("FAIL read_pulse cycle %0d: read=%b expected %b", k, o_read, exp_rd[k]);
            end
            rd_cmd = 1'b0;
            if (k < 40) begin
                rd_lat = 4'd5;
                rd_cmd = (k == 10) || (k == 20) || (k == 21);
            end else if (k < 260) begin
                rd_lat = 4'($urandom_range(1, 15));
                rd_cmd = ($urandom_range(0, 3) == 0);
            end
            if (rd_cmd) begin
                for (int j = 0; j < 2; j++) exp_rd[k + int'(rd_lat) + j] = 1'b1;
            end
        end
        rd_cmd = 1'b0;
    endtask

    task automatic run_cal(input string name, input bit spam);
        bit ok;
        int e_lat, e_dly, e_f, e_l;
        int bad, bl, bd;
        int pol_bad;
        bit fin;
        compute_expect(ok, e_lat, e_dly, e_f, e_l);
        foreach (ack_cnt[a, b]) ack_cnt[a][b] = 0;
        model_en = 1'b1; rd_lat = 4'd5; rd_cmd = 1'b0;
        @(negedge clk); cal_start = 1'b1;
        @(negedge clk); cal_start = 1'b0;
        n_tests++;
        if (o_cal_busy !== 1'b1 || o_cal_done !== 1'b0 || o_cal_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: busy/done/err=%b%b%b want 100", name, o_cal_busy, o_cal_done, o_cal_err);
        end
        fin = 1'b0; pol_bad = 0;
        for (int i = 0; i < 40000 && !fin; i++) begin
            @(negedge clk);
            cal_start = 1'b0;
            if (o_dyndelpol !== 1'b0) pol_bad++;
            if (o_cal_done === 1'b1 || o_cal_err === 1'b1) fin = 1'b1;
            else if (spam && o_cal_busy === 1'b1 && $urandom_range(0, 29) == 0) cal_start = 1'b1;
        end
        cal_start = 1'b0;
        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s timeout: done/err never set within 40000 cycles", name);
        end
        n_tests++;
        if (pol_bad != 0) begin
            n_fail++;
            $display("FAIL %s dyndelpol: high in %0d cycles want 0", name, pol_bad);
        end
        n_tests++;
        if (o_cal_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s cal_busy: got %b want 0", name, o_cal_busy);
        end
        if (ok) begin
            n_tests++;
            if (o_cal_done !== 1'b1 || o_cal_err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done/err: got %b%b want 10", name, o_cal_done, o_cal_err);
            end
            n_tests++;
            if (int'(o_lat_ofs) != e_lat || int'(o_dyndelay) != e_dly) begin
                n_fail++;
                $display("FAIL %s lat_ofs/dyndelay: got %0d/%0d want %0d/%0d",
                         name, o_lat_ofs, o_dyndelay, e_lat, e_dly);
            end
            n_tests++;
            if (int'(o_win_first) != e_f || int'(o_win_last) != e_l) begin
                n_fail++;
                $display("FAIL %s window: got %0d..%0d want %0d..%0d",
                         name, o_win_first, o_win_last, e_f, e_l);
            end
        end else begin
            n_tests++;
            if (o_cal_err !== 1'b1 || o_cal_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done/err: got %b%b want 01", name, o_cal_done, o_cal_err);
            end
            n_tests++;
            if (o_lat_ofs !== 3'd0 || o_dyndelay !== 7'd0) begin
                n_fail++;
                $display("FAIL %s err lat_ofs/dyndelay: got %0d/%0d want 0/0", name, o_lat_ofs, o_dyndelay);
            end
        end
        bad = 0; bl = 0; bd = 0;
        for (int l = 0; l < 8; l++) begin
            for (int d = 0; d < 128; d++) begin
                if (ack_cnt[l][d] != exp_acks[l][d]) begin
                    if (bad == 0) begin bl = l; bd = d; end
                    bad++;
                end
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s trial_count: %0d settings wrong, first lat %0d dly %0d got %0d want %0d",
                     name, bad, bl, bd, ack_cnt[bl][bd], exp_acks[bl][bd]);
        end
        $display("[TB] %s: lat_ofs=%0d dyndelay=%0d window=%0d..%0d done=%b err=%b",
                 name, o_lat_ofs, o_dyndelay, o_win_first, o_win_last, o_cal_done, o_cal_err);
    endtask

    task automatic test_reset_midcal();
        bit found;
        logic [29:0] outs;
        set_no_windows();
        rand_timing = 1'b0; fixed_d = 3; noise_en = 1'b0;
        model_en = 1'b1; rd_lat = 4'd5;
        @(negedge clk); cal_start = 1'b1;
        @(negedge clk); cal_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (last_ack_dly == 37 && last_ack_cyc == cyc) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midcal_reach: trial read at dyndelay 37 not seen within 5000 cycles");
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        outs = {o_cal_rd_req, o_read, o_dyndelay, o_dyndelpol, o_lat_ofs, o_cal_busy,
                o_cal_done, o_cal_err, o_win_first, o_win_last};
        n_tests++;
        if (outs !== 30'd0) begin
            n_fail++;
            $display("FAIL midcal_reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++;
        if (o_cal_busy !== 1'b0 || o_cal_rd_req !== 1'b0 || o_dyndelay !== 7'd0) begin
            n_fail++;
            $display("FAIL midcal_idle: busy/req/dly=%b/%b/%0d want 0/0/0",
                     o_cal_busy, o_cal_rd_req, o_dyndelay);
        end
        model_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cal_start = 1'b0; rd_cmd = 1'b0; rd_lat = 4'd0;
        set_no_windows();
        test_reset();
        test_read_pulse();

        set_no_windows();
        win_lo[0] = 40; win_hi[0] = 60;
        rand_timing = 1'b0; fixed_d = 16; noise_en = 1'b1;
        run_cal("win40_60_dv16", 1'b0);

        rand_timing = 1'b1;
        run_cal("win40_60_start_spam", 1'b1);

        set_no_windows();
        win_lo[2] = 10; win_hi[2] = 19;
        rand_timing = 1'b1; noise_en = 1'b1;
        run_cal("lat2_win10_19", 1'b0);

        set_no_windows();
        win_lo[0] = 30; win_hi[0] = 32;
        win_lo[1] = 70; win_hi[1] = 90;
        rand_timing = 1'b1; noise_en = 1'b0;
        run_cal("narrow_then_70_90", 1'b0);

        // datavalid one cycle after the timeout never counts: full sweep to error.
        for (int l = 0; l < 8; l++) begin win_lo[l] = 0; win_hi[l] = 127; end
        rand_timing = 1'b0; fixed_d = 17; noise_en = 1'b0;
        run_cal("late_dv_err", 1'b0);

        test_reset_midcal();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
